// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between instruction fetch and the MEM-stage
// load/store port. Data has priority, bounded by MAX_DATA_RUN to keep fetch alive.
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES    = 256,
   parameter int unsigned MAX_DATA_RUN = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_gnt,
   output logic [31:0]      if_rdata,
   output logic             if_err,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [2:0]       d_func3,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_gnt,
   output logic [31:0]      d_rdata,
   output logic             d_err,
   output logic             mem_read,
   output logic             mem_write,
   output logic [2:0]       mem_func3,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [3:0]  MaxRun   = 4'(MAX_DATA_RUN);
   localparam logic [31:0] IfLast   = 32'(MEM_BYTES - 4);
   localparam logic [32:0] LastByte = 33'(MEM_BYTES - 1);

   logic [3:0]       run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] conflict_q;
   logic             fetch_wins;
   logic             if_bad;
   logic             d_bad;
   logic             d_bad_op;
   logic             d_misalign;
   logic [2:0]       d_span;
   logic [32:0]      d_end;

   always_comb begin
      fetch_wins = if_req && (!d_req || (run_cnt_q == MaxRun));
      if_gnt     = !rst && fetch_wins;
      d_gnt      = !rst && d_req && !fetch_wins;
   end

   always_comb begin
      if_bad = (if_addr[1:0] != 2'b00) || (if_addr > IfLast);

      unique case (d_func3[1:0])
         2'b00:   d_span = 3'd0;
         2'b01:   d_span = 3'd1;
         default: d_span = 3'd3;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range.
      d_end = {1'b0, d_addr} + {30'b0, d_span};

      if (d_we) begin
         d_bad_op = d_func3[2] || (d_func3[1:0] == 2'b11);
      end else begin
         d_bad_op = (d_func3 == 3'b011) || (d_func3[2:1] == 2'b11);
      end
      d_misalign = ((d_func3[1:0] == 2'b01) && d_addr[0]) ||
                   ((d_func3 == 3'b010) && (d_addr[1:0] != 2'b00));
      d_bad      = d_bad_op || d_misalign || (d_end > LastByte);

      if_err = if_gnt && if_bad;
      d_err  = d_gnt && d_bad;
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_func3 = 3'b000;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (if_gnt && !if_bad) begin
         mem_read  = 1'b1;
         mem_func3 = 3'b010;
         mem_addr  = if_addr;
      end else if (d_gnt && !d_bad) begin
         mem_read  = !d_we;
         mem_write = d_we;
         mem_func3 = d_func3;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
      if_rdata = (if_gnt && mem_read) ? mem_rdata : 32'h0;
      d_rdata  = (d_gnt && mem_read) ? mem_rdata : 32'h0;
   end

   // Counts consecutive data grants won while fetch was waiting.
   always_comb begin
      if (if_gnt || !if_req) begin
         run_cnt_d = 4'd0;
      end else if (d_gnt) begin
         run_cnt_d = run_cnt_q + 4'd1;
      end else begin
         run_cnt_d = run_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q  <= 4'd0;
         conflict_q <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
         if (if_req && d_req && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 1'b1;
         end
      end
   end

   assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a byte-array memory and a reference model of
// arbitration, access checking and memory contents.
module tb_dmem_arbiter;

   localparam int MemBytes = 256;
   localparam int MaxRun   = 4;
   localparam int CntW     = 4;
   localparam int CntMax   = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_req;
   logic [31:0]     if_addr;
   logic            if_gnt;
   logic [31:0]     if_rdata;
   logic            if_err;
   logic            d_req;
   logic            d_we;
   logic [2:0]      d_func3;
   logic [31:0]     d_addr;
   logic [31:0]     d_wdata;
   logic            d_gnt;
   logic [31:0]     d_rdata;
   logic            d_err;
   logic            mem_read;
   logic            mem_write;
   logic [2:0]      mem_func3;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;
   logic [CntW-1:0] conflict_cnt;

   dmem_arbiter #(
      .MEM_BYTES(MemBytes),
      .MAX_DATA_RUN(MaxRun),
      .CNT_W(CntW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_gnt(if_gnt),
      .if_rdata(if_rdata),
      .if_err(if_err),
      .d_req(d_req),
      .d_we(d_we),
      .d_func3(d_func3),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_gnt(d_gnt),
      .d_rdata(d_rdata),
      .d_err(d_err),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_func3(mem_func3),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Memory seen by the DUT (padded so a word at the last byte never indexes off the end).
   logic [7:0]  env_mem [MemBytes+4];
   logic [7:0]  ref_mem [MemBytes];
   logic        preload;
   logic [31:0] env_w;

   function automatic logic [7:0] init_byte(int i);
      case (i)
         0:       return 8'h11;
         4:       return 8'h09;
         5, 6, 7: return 8'h00;
         8:       return 8'h19;
         default: return 8'(i * 7 + 3);
      endcase
   endfunction

   always_comb begin
      env_w     = 32'h0;
      mem_rdata = 32'hA5A5_A5A5;
      if (mem_read && (mem_addr < 32'(MemBytes))) begin
         env_w = {env_mem[int'(mem_addr) + 3], env_mem[int'(mem_addr) + 2],
                  env_mem[int'(mem_addr) + 1], env_mem[int'(mem_addr)]};
         case (mem_func3)
            3'b000:  mem_rdata = {{24{env_w[7]}}, env_w[7:0]};
            3'b001:  mem_rdata = {{16{env_w[15]}}, env_w[15:0]};
            3'b100:  mem_rdata = {24'h0, env_w[7:0]};
            3'b101:  mem_rdata = {16'h0, env_w[15:0]};
            default: mem_rdata = env_w;
         endcase
      end
   end

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < MemBytes + 4; i++) env_mem[i] <= init_byte(i);
      end else if (mem_write && (mem_addr < 32'(MemBytes))) begin
         env_mem[int'(mem_addr)] <= mem_wdata[7:0];
         if (mem_func3[1:0] != 2'b00) env_mem[int'(mem_addr) + 1] <= mem_wdata[15:8];
         if (mem_func3[1]) begin
            env_mem[int'(mem_addr) + 2] <= mem_wdata[23:16];
            env_mem[int'(mem_addr) + 3] <= mem_wdata[31:24];
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          run = 0;
   int          conf = 0;
   int          nrun, nconf;
   bit          pend_st;
   longint      pend_addr;
   int          pend_size;
   logic [31:0] pend_data;

   function automatic int size_of(int f3);
      return (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
   endfunction

   function automatic bit data_illegal(bit we, int f3, longint addr);
      bit legal_op;
      int sz;
      legal_op = we ? (f3 inside {0, 1, 2}) : (f3 inside {0, 1, 2, 4, 5});
      sz = size_of(f3);
      if (!legal_op) return 1'b1;
      if (addr % sz != 0) return 1'b1;
      return (addr + sz - 1) > (MemBytes - 1);
   endfunction

   function automatic logic [31:0] ref_load(longint addr, int f3);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < size_of(f3); i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
      if (f3 == 0 && v[7]) v = v | 32'hFFFF_FF00;
      if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   // Drive one cycle's inputs and check every output against the model mid-cycle.
   task automatic apply(bit r, bit ir, logic [31:0] ia, bit dr, bit we, logic [2:0] f3,
                        logic [31:0] da, logic [31:0] wd);
      bit          fw, eig, edg, eie, ede, er, ew;
      logic [2:0]  ef;
      logic [31:0] ea, ewd, eir, edr;
      rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = we;
      d_func3 = f3; d_addr = da; d_wdata = wd;
      #3;
      fw  = ir && (!dr || run == MaxRun);
      eig = !r && fw;
      edg = !r && dr && !fw;
      eie = eig && ((longint'(ia) % 4 != 0) || (longint'(ia) > MemBytes - 4));
      ede = edg && data_illegal(we, int'(f3), longint'(da));
      er = 0; ew = 0; ef = 3'b0; ea = 0; ewd = 0; eir = 0; edr = 0;
      if (eig && !eie) begin
         er = 1; ef = 3'b010; ea = ia; eir = ref_load(longint'(ia), 2);
      end
      if (edg && !ede) begin
         er = !we; ew = we; ef = f3; ea = da; ewd = wd;
         if (!we) edr = ref_load(longint'(da), int'(f3));
      end
      check("if_gnt", if_gnt, eig);
      check("d_gnt", d_gnt, edg);
      check("if_err", if_err, eie);
      check("d_err", d_err, ede);
      check("mem_read", mem_read, er);
      check("mem_write", mem_write, ew);
      check("mem_func3", mem_func3, ef);
      check("mem_addr", mem_addr, ea);
      if (!eig) check("mem_wdata", mem_wdata, ewd);
      check("if_rdata", if_rdata, eir);
      check("d_rdata", d_rdata, edr);
      check("conflict_cnt", conflict_cnt, 32'(conf));
      pend_st = ew; pend_addr = longint'(da); pend_size = size_of(int'(f3)); pend_data = wd;
      if (r) begin
         nrun = 0; nconf = 0;
      end else begin
         nrun  = (!ir || eig) ? 0 : (edg ? run + 1 : run);
         nconf = (ir && dr && conf < CntMax) ? conf + 1 : conf;
      end
   endtask

   task automatic tick();
      if (pend_st) begin
         for (int i = 0; i < pend_size; i++) ref_mem[int'(pend_addr) + i] = 8'(pend_data >> (8 * i));
      end
      run = nrun;
      conf = nconf;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(bit r);
      apply(r, 1'b0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      tick();
   endtask

   initial begin
      logic [31:0] ia, da;
      logic [2:0]  f3;
      for (int i = 0; i < MemBytes; i++) ref_mem[i] = init_byte(i);
      preload = 1'b1;
      rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
      d_func3 = 0; d_addr = 0; d_wdata = 0;
      @(posedge clk);
      #1;
      preload = 1'b0;

      // Reset holds off both grants and any store.
      apply(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h1234_5678);
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_write", mem_write, 0);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      check("rst_conflict", conflict_cnt, 0);
      tick();
      check("rst_mem0", env_mem[0], 8'h11);

      // Solo fetch and solo load.
      apply(1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      check("fetch_func3", mem_func3, 3'b010);
      check("fetch_rdata", if_rdata, 32'h0000_0009);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b000, 32'd8, 32'h0);
      check("lb_rdata", d_rdata, 32'h0000_0019);
      tick();

      // Starvation bound: four data wins then one fetch.
      idle(1'b1);
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 1'b1, 32'd16, 1'b1, 1'b0, 3'b010, 32'd20, 32'h0);
         check("starve_seq", {30'b0, if_gnt, d_gnt}, (i % 5 == 4) ? 32'd2 : 32'd1);
         tick();
      end
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      check("conflict_10", conflict_cnt, 10);
      tick();

      // Store then narrower loads.
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'd12, 32'hDEAD_BEEF);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b001, 32'd14, 32'h0);
      check("lh_rdata", d_rdata, 32'hFFFF_DEAD);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b100, 32'd12, 32'h0);
      check("lbu_rdata", d_rdata, 32'h0000_00EF);
      tick();

      // Error cases.
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'd2, 32'h0);
      check("lw_mis_err", d_err, 1);
      check("lw_mis_read", mem_read, 0);
      check("lw_mis_rdata", d_rdata, 0);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b001, 32'd255, 32'h5555_5555);
      check("sh_oob_err", d_err, 1);
      check("sh_oob_write", mem_write, 0);
      tick();
      check("sh_oob_mem", env_mem[255], 8'hFC);
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b100, 32'd0, 32'h0);
      check("st_f3_err", d_err, 1);
      tick();
      apply(1'b0, 1'b1, 32'd254, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      check("if_oob_err", if_err, 1);
      tick();

      // Counter saturation, and reset clearing a full data run.
      idle(1'b1);
      for (int i = 0; i < 24; i++) begin
         apply(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 3'b100, 32'd3, 32'h0);
         tick();
      end
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
      check("conflict_sat", conflict_cnt, 15);
      // Leave run at its limit, then reset with both requests pending.
      apply(1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 3'b100, 32'd3, 32'h0);
      tick();
      apply(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 3'b100, 32'd3, 32'h0);
      check("post_rst_cnt", conflict_cnt, 0);
      check("post_rst_dgnt", d_gnt, 1);
      tick();

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         ia = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MemBytes + 3));
         if ($urandom_range(0, 2) != 0) ia[1:0] = 2'b00;
         da = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MemBytes + 3));
         if ($urandom_range(0, 1) != 0) da[1:0] = 2'b00;
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) f3[2] = 1'b1;
         apply($urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7, ia,
               $urandom_range(0, 9) < 7, 1'($urandom), f3, da, $urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
